// File: rtl/trigger_chain_cfg_sequencer.sv
// Wishbone coefficient sequencer for the pre-trigger biquad chain: replays a staged
// (address, data) table under biquad reset and passes host cycles through between updates.
module trigger_chain_cfg_sequencer #(
    parameter int DEPTH       = 32,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    // host Wishbone target
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [21:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o,
    output logic [31:0]              wb_dat_o,
    // biquad Wishbone master
    output logic                     bq_cyc_o,
    output logic                     bq_stb_o,
    output logic                     bq_we_o,
    output logic [21:0]              bq_adr_o,
    output logic [31:0]              bq_dat_o,
    output logic [3:0]               bq_sel_o,
    input  logic                     bq_ack_i,
    input  logic                     bq_err_i,
    input  logic                     bq_rty_i,
    input  logic [31:0]              bq_dat_i,
    // shadow table and update control
    input  logic                     tbl_we_i,
    input  logic [$clog2(DEPTH)-1:0] tbl_idx_i,
    input  logic [21:0]              tbl_adr_i,
    input  logic [31:0]              tbl_dat_i,
    input  logic                     commit_i,
    input  logic [$clog2(DEPTH):0]   commit_len_i,
    output logic                     bq_reset_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_PRE,
        S_WRITE,
        S_POST,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_idx;
    logic [LW-1:0]   r_pend_len;
    logic            r_pending;
    logic [TW-1:0]   r_tmo_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_bq_cyc;
    logic [21:0]     r_bq_adr;
    logic [31:0]     r_bq_dat;
    logic            r_bq_reset;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;

    logic [21:0]     r_tbl_adr [DEPTH];
    logic [31:0]     r_tbl_dat [DEPTH];

    logic            w_in_host;
    logic            w_host_req;
    logic            w_bq_term;
    logic            w_accept;
    logic            w_tbl_we;
    logic [LW-1:0]   w_clamp_len;
    logic [LW-1:0]   w_idx_nxt;

    assign w_in_host   = (r_state == S_HOST);
    assign w_host_req  = wb_cyc_i & wb_stb_i;
    assign w_bq_term   = bq_ack_i | bq_err_i | bq_rty_i;
    assign w_accept    = (r_state == S_IDLE) & (commit_i | r_pending);
    assign w_clamp_len = (commit_len_i > LW'(DEPTH)) ? LW'(DEPTH) : commit_len_i;
    assign w_idx_nxt   = r_idx + 1'b1;
    // The table freezes at commit acceptance, so a write in that same cycle is dropped.
    assign w_tbl_we    = tbl_we_i & ~r_busy & ~w_accept;

    // NOTE: the shadow table has no reset; its contents must survive aresetn and it maps to plain storage.
    always_ff @(posedge aclk) begin
        if (w_tbl_we) begin
            r_tbl_adr[tbl_idx_i] <= tbl_adr_i;
            r_tbl_dat[tbl_idx_i] <= tbl_dat_i;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_pend_len <= '0;
            r_pending  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_hold_cnt <= '0;
            r_bq_cyc   <= 1'b0;
            r_bq_adr   <= '0;
            r_bq_dat   <= '0;
            r_bq_reset <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len      <= commit_i ? w_clamp_len : r_pend_len;
                        r_pending  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bq_reset <= 1'b1;
                        r_state    <= S_PRE;
                    end else if (w_host_req) begin
                        r_state <= S_HOST;
                    end
                end
                S_HOST: begin
                    if (commit_i) begin
                        r_pending  <= 1'b1;
                        r_pend_len <= w_clamp_len;
                    end
                    if (w_bq_term || !wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_PRE: begin
                    r_idx      <= '0;
                    r_tmo_cnt  <= '0;
                    r_hold_cnt <= '0;
                    if (r_len == '0) begin
                        r_state <= S_POST;
                    end else begin
                        r_bq_cyc <= 1'b1;
                        r_bq_adr <= r_tbl_adr[0];
                        r_bq_dat <= r_tbl_dat[0];
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_bq_cyc) begin
                        if (bq_ack_i || bq_err_i) begin
                            r_bq_cyc  <= 1'b0;
                            r_idx     <= w_idx_nxt;
                            r_tmo_cnt <= '0;
                            if (w_idx_nxt == r_len) begin
                                r_state <= S_POST;
                            end
                        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                            r_bq_cyc  <= 1'b0;
                            r_timeout <= 1'b1;
                            r_state   <= S_POST;
                        end else begin
                            // Retries keep accumulating against the same per-entry budget.
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                            if (bq_rty_i) begin
                                r_bq_cyc <= 1'b0;
                            end
                        end
                    end else begin
                        r_bq_cyc <= 1'b1;
                        r_bq_adr <= r_tbl_adr[r_idx[IW-1:0]];
                        r_bq_dat <= r_tbl_dat[r_idx[IW-1:0]];
                    end
                end
                S_POST: begin
                    if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        r_bq_reset <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Host cycles are a combinational pass-through; otherwise the master is register driven.
    assign bq_cyc_o = w_in_host ? wb_cyc_i : r_bq_cyc;
    assign bq_stb_o = w_in_host ? wb_stb_i : r_bq_cyc;
    assign bq_we_o  = w_in_host ? wb_we_i  : r_bq_cyc;
    assign bq_sel_o = w_in_host ? wb_sel_i : {4{r_bq_cyc}};
    assign bq_adr_o = w_in_host ? wb_adr_i : (r_bq_cyc ? r_bq_adr : '0);
    assign bq_dat_o = w_in_host ? wb_dat_i : (r_bq_cyc ? r_bq_dat : '0);

    assign wb_ack_o = w_in_host & bq_ack_i;
    assign wb_err_o = w_in_host & bq_err_i;
    assign wb_rty_o = w_in_host & bq_rty_i;
    assign wb_dat_o = w_in_host ? bq_dat_i : '0;

    assign bq_reset_o = r_bq_reset;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_trigger_chain_cfg_sequencer.sv
// Self-checking bench for trigger_chain_cfg_sequencer: update vectors from a table,
// a write scoreboard fed at stimulus time, and hand sequences for host/reset corners.
module tb_trigger_chain_cfg_sequencer;

    localparam int DEPTH = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [21:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] wb_dat_o;
    logic        bq_cyc_o, bq_stb_o, bq_we_o;
    logic [21:0] bq_adr_o;
    logic [31:0] bq_dat_o;
    logic [3:0]  bq_sel_o;
    logic        bq_ack_i, bq_err_i, bq_rty_i;
    logic [31:0] bq_dat_i;
    logic        tbl_we_i;
    logic [4:0]  tbl_idx_i;
    logic [21:0] tbl_adr_i;
    logic [31:0] tbl_dat_i;
    logic        commit_i;
    logic [5:0]  commit_len_i;
    logic        bq_reset_o, busy_o, done_o, timeout_o;

    trigger_chain_cfg_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(16), .TIMEOUT(255)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
        .bq_cyc_o(bq_cyc_o), .bq_stb_o(bq_stb_o), .bq_we_o(bq_we_o),
        .bq_adr_o(bq_adr_o), .bq_dat_o(bq_dat_o), .bq_sel_o(bq_sel_o),
        .bq_ack_i(bq_ack_i), .bq_err_i(bq_err_i), .bq_rty_i(bq_rty_i), .bq_dat_i(bq_dat_i),
        .tbl_we_i(tbl_we_i), .tbl_idx_i(tbl_idx_i), .tbl_adr_i(tbl_adr_i), .tbl_dat_i(tbl_dat_i),
        .commit_i(commit_i), .commit_len_i(commit_len_i),
        .bq_reset_o(bq_reset_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int len;
        int lat;
        bit never;
        bit rty;
        int exp_wr;
        int exp_starts;
        int exp_rst;
        bit exp_tmo;
    } upd_vec_t;

    typedef struct {
        logic [21:0] adr;
        logic [31:0] dat;
    } wr_t;

    upd_vec_t    vecs[6];
    wr_t         exp_q[$];
    logic [21:0] m_adr[DEPTH];
    logic [31:0] m_dat[DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    // target model knobs and monitor counters
    int          tgt_lat   = 1;
    bit          tgt_never = 1'b0;
    bit          tgt_rty   = 1'b0;
    logic [31:0] tgt_rdata = 32'h0;
    int          tgt_cnt   = 0;
    int          rst_cnt   = 0;
    int          done_cnt  = 0;
    int          cyc_starts = 0;
    bit          prev_cyc  = 1'b0;
    bit          saw_we    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Biquad target: acks after tgt_lat request cycles, optionally one retry first, or never.
    initial begin
        bq_ack_i = 1'b0; bq_err_i = 1'b0; bq_rty_i = 1'b0; bq_dat_i = '0;
        forever begin
            @(posedge aclk);
            #2;
            bq_ack_i = 1'b0; bq_err_i = 1'b0; bq_rty_i = 1'b0; bq_dat_i = '0;
            if (bq_cyc_o && bq_stb_o) begin
                tgt_cnt++;
                if (!tgt_never && tgt_cnt >= tgt_lat) begin
                    if (tgt_rty) begin
                        bq_rty_i = 1'b1;
                        tgt_rty  = 1'b0;
                    end else begin
                        bq_ack_i = 1'b1;
                        bq_dat_i = tgt_rdata;
                    end
                    tgt_cnt = 0;
                end
            end else begin
                tgt_cnt = 0;
            end
        end
    end

    // Monitor and scoreboard: every acknowledged bq write is popped against the expected queue.
    always @(negedge aclk) begin
        if (bq_cyc_o === 1'b1 && !prev_cyc) cyc_starts++;
        prev_cyc = (bq_cyc_o === 1'b1);
        if (bq_reset_o === 1'b1) rst_cnt++;
        if (done_o === 1'b1) done_cnt++;
        if (bq_we_o === 1'b1) saw_we = 1'b1;
        if (bq_cyc_o === 1'b1 && bq_stb_o === 1'b1 && bq_we_o === 1'b1 && bq_ack_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got write adr 0x%0h dat 0x%0h, expected no write", bq_adr_o, bq_dat_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_adr", {10'd0, bq_adr_o}, {10'd0, e.adr});
                check("sb_dat", bq_dat_o, e.dat);
                check("sb_sel", {28'd0, bq_sel_o}, 32'hF);
            end
        end
    end

    task automatic run_update(input upd_vec_t v, input string tag);
        bit found;
        tgt_lat   = v.lat;
        tgt_never = v.never;
        tgt_rty   = v.rty;
        for (int i = 0; i < v.exp_wr; i++) exp_q.push_back('{adr: m_adr[i], dat: m_dat[i]});
        rst_cnt = 0; done_cnt = 0; cyc_starts = 0;
        commit_i     = 1'b1;
        commit_len_i = 6'(v.len);
        tick();
        commit_i     = 1'b0;
        @(negedge aclk);
        check({tag, "_pre_busy"}, {31'd0, busy_o}, 1);
        check({tag, "_pre_reset"}, {31'd0, bq_reset_o}, 1);
        check({tag, "_pre_nocyc"}, {31'd0, bq_cyc_o}, 0);
        found = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge aclk);
            if (done_o) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, found}, 1);
        @(negedge aclk);
        check({tag, "_idle_busy"}, {31'd0, busy_o}, 0);
        check({tag, "_idle_reset"}, {31'd0, bq_reset_o}, 0);
        check({tag, "_rst_cycles"}, rst_cnt, v.exp_rst);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_cyc_starts"}, cyc_starts, v.exp_starts);
        check({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, v.exp_tmo});
        check({tag, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
        tgt_never = 1'b0;
        tgt_rty   = 1'b0;
        tick();
    endtask

    initial begin
        bit found;
        bit done_seen;
        int n;

        //           len lat nev rty wr starts rst tmo
        vecs[0] = '{ 3,  1,  0,  0,  3,  3,    22, 0};  // basic 3-entry replay
        vecs[1] = '{ 3,  2,  0,  0,  3,  3,    25, 0};  // slower target
        vecs[2] = '{ 2,  1,  1,  0,  0,  1,   272, 1};  // entry 1 never acked
        vecs[3] = '{ 0,  1,  0,  0,  0,  0,    17, 0};  // empty update, clears timeout
        vecs[4] = '{40,  1,  0,  0, 32, 32,    80, 0};  // length clamps to DEPTH
        vecs[5] = '{ 1,  1,  0,  1,  1,  2,    20, 0};  // one retry then ack

        aresetn  = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        tbl_we_i = 1'b0; tbl_idx_i = '0; tbl_adr_i = '0; tbl_dat_i = '0;
        commit_i = 1'b0; commit_len_i = '0;
        repeat (3) tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_bq_reset", {31'd0, bq_reset_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        check("rst_timeout", {31'd0, timeout_o}, 0);
        check("rst_bq_cyc", {31'd0, bq_cyc_o}, 0);
        check("rst_wb_ack", {31'd0, wb_ack_o}, 0);
        tick();

        // stage the whole table; the first three entries are the reference coefficients
        for (int i = 0; i < DEPTH; i++) begin
            m_adr[i] = (i < 3) ? 22'h100 + 22'(4 * i) : 22'h1000 + 22'(4 * i);
            m_dat[i] = (i < 3) ? 32'hA + 32'(i) : $urandom;
            tbl_we_i  = 1'b1;
            tbl_idx_i = 5'(i);
            tbl_adr_i = m_adr[i];
            tbl_dat_i = m_dat[i];
            tick();
        end
        tbl_we_i = 1'b0;

        for (int i = 0; i < 6; i++) run_update(vecs[i], $sformatf("vec%0d", i));

        // host read in IDLE, target answers on its second cycle
        tgt_lat = 2; tgt_rdata = 32'hDEADBEEF; saw_we = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 22'h200; wb_sel_i = 4'hF;
        found = 1'b0; n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge aclk);
            if (wb_ack_o) begin
                found = 1'b1; n = k;
                check("host_rd_data", wb_dat_o, 32'hDEADBEEF);
                check("host_rd_adr", {10'd0, bq_adr_o}, 32'h200);
                break;
            end
        end
        check("host_rd_ack", {31'd0, found}, 1);
        check("host_rd_latency", n, 3);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge aclk);
        check("host_rd_release", {31'd0, bq_cyc_o}, 0);
        check("host_rd_no_we", {31'd0, saw_we}, 0);
        tick();

        // host write two cycles into an update, plus table writes and a commit that must be ignored
        tgt_lat = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{adr: m_adr[i], dat: m_dat[i]});
        exp_q.push_back('{adr: 22'h300, dat: 32'h55AA1234});
        cyc_starts = 0; done_cnt = 0;
        commit_i = 1'b1; commit_len_i = 6'd3;
        tbl_we_i = 1'b1; tbl_idx_i = 5'd1; tbl_adr_i = 22'h3FFFFF; tbl_dat_i = 32'hBAD00001;
        tick();
        commit_i = 1'b0; tbl_we_i = 1'b0;
        tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 22'h300; wb_dat_i = 32'h55AA1234; wb_sel_i = 4'hF;
        tbl_we_i = 1'b1; tbl_idx_i = 5'd0; tbl_adr_i = 22'h3FFFFE; tbl_dat_i = 32'hBAD00002;
        commit_i = 1'b1; commit_len_i = 6'd5;
        tick();
        tbl_we_i = 1'b0; commit_i = 1'b0;
        found = 1'b0; done_seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (done_o) done_seen = 1'b1;
            if (wb_ack_o) begin
                found = 1'b1;
                break;
            end
        end
        check("host_wr_ack", {31'd0, found}, 1);
        check("host_wr_after_done", {31'd0, done_seen}, 1);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge aclk);
        check("host_wr_sb_left", exp_q.size(), 0);
        check("host_wr_cyc_starts", cyc_starts, 4);
        check("host_wr_done_count", done_cnt, 1);
        exp_q.delete();
        tick();

        // reset in the middle of WRITE
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{adr: m_adr[i], dat: m_dat[i]});
        commit_i = 1'b1; commit_len_i = 6'd32;
        tick();
        commit_i = 1'b0;
        repeat (6) tick();
        aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("midrst_bq_cyc", {31'd0, bq_cyc_o}, 0);
        check("midrst_bq_adr", {10'd0, bq_adr_o}, 0);
        check("midrst_bq_reset", {31'd0, bq_reset_o}, 0);
        check("midrst_busy", {31'd0, busy_o}, 0);
        check("midrst_done", {31'd0, done_o}, 0);
        check("midrst_timeout", {31'd0, timeout_o}, 0);
        exp_q.delete();
        tick();
        aresetn = 1'b1;
        tick();
        run_update(vecs[0], "replay");

        // commit seen during a host cycle is held until the host cycle ends
        tgt_lat = 3; tgt_rdata = 32'h12345678;
        exp_q.push_back('{adr: m_adr[0], dat: m_dat[0]});
        done_cnt = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 22'h204; wb_sel_i = 4'hF;
        @(negedge aclk);
        @(negedge aclk);
        tick();
        commit_i = 1'b1; commit_len_i = 6'd1;
        tick();
        commit_i = 1'b0; commit_len_i = 6'd0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (wb_ack_o) begin
                found = 1'b1;
                check("pend_busy_in_host", {31'd0, busy_o}, 0);
                check("pend_host_data", wb_dat_o, 32'h12345678);
                break;
            end
        end
        check("pend_host_ack", {31'd0, found}, 1);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (done_o) begin
                found = 1'b1;
                break;
            end
        end
        check("pend_done", {31'd0, found}, 1);
        @(negedge aclk);
        check("pend_sb_left", exp_q.size(), 0);
        check("pend_done_count", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_chain_cfg_sequencer.md
Name: trigger_chain_cfg_sequencer

Overview:
- Owns the Wishbone path into the biquad coefficient target of the pre-trigger filter chain and sequences coefficient updates.
- Host software stages a table of (address, data) writes, then issues a commit. The block holds the biquad reset, replays the table as Wishbone master writes, waits a programmable hold time, then releases the reset.
- Between updates, host Wishbone cycles pass through to the target. Host and sequencer are arbitrated so they never overlap.

Parameters:
- DEPTH, 32, number of shadow table entries (power of 2).
- HOLD_CYCLES, 16, cycles bq_reset_o stays asserted after the last write.
- TIMEOUT, 255, maximum cycles waiting for ack/err/rty on one write.

Ports:
- aclk  in  1  single clock; the downstream target's Wishbone clock is driven from this same clock.
- aresetn  in  1  synchronous active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  host Wishbone target controls.
- wb_adr_i  in  22  host address.
- wb_dat_i  in  32  host write data.
- wb_sel_i  in  4  host byte selects.
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  host cycle termination.
- wb_dat_o  out  32  host read data.
- bq_cyc_o, bq_stb_o, bq_we_o  out  1 each  master controls to the biquad target.
- bq_adr_o  out  22  master address.
- bq_dat_o  out  32  master write data.
- bq_sel_o  out  4  master byte selects.
- bq_ack_i, bq_err_i, bq_rty_i  in  1 each  target cycle termination.
- bq_dat_i  in  32  target read data.
- tbl_we_i  in  1  shadow table write strobe.
- tbl_idx_i  in  clog2(DEPTH)  table entry index.
- tbl_adr_i  in  22  entry address.
- tbl_dat_i  in  32  entry data.
- commit_i  in  1  single-cycle pulse that starts an update.
- commit_len_i  in  clog2(DEPTH)+1  number of entries to replay.
- bq_reset_o  out  1  active-high reset to the biquads.
- busy_o  out  1  high from commit acceptance through the DONE state.
- done_o  out  1  one-cycle pulse when an update completes.
- timeout_o  out  1  sticky flag: the last update aborted on timeout.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - State returns to IDLE.
  - All outputs go to 0, including bq_reset_o, timeout_o and the pending-commit flag.
  - Table contents are not cleared.
  - Reset during any state abandons the in-flight cycle immediately.
- States: IDLE, HOST, PRE, WRITE, POST, DONE.
- IDLE:
  - bq_* outputs are 0.
  - Host wb_cyc_i&wb_stb_i moves to HOST; no host ack is generated in IDLE.
  - A commit (new or pending) takes priority over a host request seen in the same cycle.
- HOST:
  - bq_cyc/stb/we/adr/dat/sel combinationally mirror the host signals.
  - wb_ack/err/rty_o and wb_dat_o combinationally mirror the target.
  - Returns to IDLE on the cycle after any termination, or when wb_cyc_i drops.
  - Minimum host latency is 1 extra cycle versus direct connection.
- commit_i in HOST: latched as pending; the update starts on return to IDLE.
- commit_i while busy_o=1: ignored.
- Accepting a commit:
  - Captures len = min(commit_len_i, DEPTH).
  - Clears timeout_o, sets busy_o, moves to PRE.
- PRE: one cycle asserting bq_reset_o; entry index cleared to 0.
- PRE exit: if len=0, go to POST; otherwise go to WRITE.
- WRITE:
  - Drives bq_cyc=bq_stb=bq_we=1, bq_sel=4'hF, with address and data from table[idx], held stable until termination.
  - ack or err: idx++. If idx reaches len, go to POST; otherwise drop cyc/stb for 1 cycle and issue the next entry.
  - rty: the same entry is reissued after a 1-cycle gap; retries count toward the same timeout.
  - Per-entry counter saturating at TIMEOUT: abort the cycle, set timeout_o, go to POST.
- Host during an update: host requests get no termination until the update reaches DONE. They are then served via IDLE→HOST.
- POST:
  - bq_reset_o stays high for exactly HOLD_CYCLES cycles.
  - It deasserts on the transition to DONE.
- DONE:
  - One cycle with done_o=1, then IDLE.
  - busy_o falls on the IDLE cycle.
- Table writes: accepted only when busy_o=0; ignored otherwise. The table is single-port registers.
- tbl_idx_i wrap: index is modulo DEPTH, no error.
- Simultaneous tbl_we_i and an accepted commit: the write is dropped (the table is frozen from acceptance).

Test Plan:
- Load 3 entries (0x100/0xA, 0x104/0xB, 0x108/0xC), commit len=3, target acks in 1 cycle → three bq write cycles in order with 1-cycle gaps. bq_reset_o high from PRE through HOLD_CYCLES=16 after the third ack. done_o pulses once, timeout_o=0.
- Host read at 0x200 while IDLE, target returns 0xDEADBEEF with ack after 2 cycles → wb_dat_o=0xDEADBEEF with wb_ack_o; bq_we_o=0 throughout.
- Host write issued 2 cycles into an update → no wb_ack_o until after done_o. Exactly one bq cycle to the host address follows DONE.
- Target never acks entry 1 of 2 → after 255 cycles the cycle is dropped. timeout_o=1, POST hold runs, done_o pulses, entry 2 is never issued.
- Commit len=0 → bq_reset_o high for 1+16 cycles, no bq_cyc_o, done_o pulses. Commit len=40 with DEPTH=32 → 32 writes.
- aresetn low mid-WRITE → next cycle all outputs 0 and state IDLE. A subsequent commit replays the unchanged table contents.
